dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//   Shares the single Data_Memory port between the core load/store path and a DMA/loader requester.
//   Arbitration is round-robin.
//   - Arbitration decision and grant are combinational in the request cycle.
//   - Read data is registered and returned one cycle after the grant.
//   - A misaligned word access raises an error pulse and is blocked at the memory.
//   Sits between single_cycle_top's ALU/RD2 path and Data_Memory.
//   core_stall feeds the PC/RegWrite hold logic.
// PARAMETERS
//   AW  32  address width (byte address; word aligned when addr[1:0]==0)
//   DW  32  data width
// PORTS
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous reset, active-low
//   core_req     in   1   core requests an access this cycle
//   core_we      in   1   1=store, 0=load
//   core_addr    in   AW  core byte address
//   core_wd      in   DW  core store data
//   core_gnt     out  1   core access performed at this clock edge
//   core_rvalid  out  1   core_rd valid (one cycle after a load grant)
//   core_rd      out  DW  core load data (registered)
//   core_stall   out  1   core_req & ~core_gnt
//   dma_req      in   1   DMA requests an access this cycle
//   dma_we       in   1   1=write, 0=read
//   dma_addr     in   AW  DMA byte address
//   dma_wd       in   DW  DMA write data
//   dma_gnt      out  1   DMA access performed at this clock edge
//   dma_rvalid   out  1   dma_rd valid (one cycle after a read grant)
//   dma_rd       out  DW  DMA read data (registered)
//   mem_A        out  AW  to Data_Memory A
//   mem_WE       out  1   to Data_Memory WE
//   mem_WD       out  DW  to Data_Memory WD
//   mem_RD       in   DW  from Data_Memory RD (combinational read)
//   align_err    out  1   registered pulse: granted access had addr[1:0]!=0
// BEHAVIOUR
//   Reset (rst==0, async):
//     - last_owner<=DMA, so the core wins the first tie.
//     - core_rd, dma_rd <= 0.
//     - core_rvalid, dma_rvalid, align_err <= 0.
//     - Combinational outputs are forced to 0 while rst==0: gnt, mem_WE, core_stall.
//   Arbitration (combinational, every cycle):
//     - Only core_req -> core wins.
//     - Only dma_req -> DMA wins.
//     - Both requesting -> the requester that was NOT last_owner wins (strict alternation).
//     - Neither requesting -> no grant; mem_WE=0; mem_A/mem_WD = core inputs (don't care).
//   Winner's addr/wd drive mem_A/mem_WD.
//   mem_WE = winner_we & (addr[1:0]==0).
//   Requester holds req/we/addr/wd stable until it sees gnt; gnt is a one-cycle pulse per access.
//   At the granting clock edge:
//     - last_owner <= winner; unchanged when idle.
//     - Load/read: winner's rd <= mem_RD, and its rvalid <= 1 for exactly one cycle.
//     - Store/write: Data_Memory commits at this edge; no rvalid.
//     - Misaligned access: align_err <= 1 for one cycle; the store is dropped.
//     - Misaligned load: rd <= 0 with rvalid still pulsed, so the handshake completes.
//   rvalid and the rd register of the loser are not disturbed; rd holds its value until the next load.
//   Throughput: 1 access/cycle total.
//   Fairness: under continuous contention each side receives every other cycle, so worst-case core stall is 1 cycle.
//   Back-to-back core loads: rvalid may stay high for consecutive cycles, each carrying new data.
//   Reset asserted mid-access: the pending rvalid is lost; no memory write occurs while rst==0.
//   Requester deasserts req without a grant: legal; no state change.
// TESTING
//   1 Reset then core_req load addr 0x10 (mem=0xDEADBEEF), no DMA
//     -> core_gnt same cycle; next cycle core_rvalid=1, core_rd=0xDEADBEEF.
//   2 Both req from reset, held 4 cycles
//     -> grants core,DMA,core,DMA; core_stall high on cycles 2,4 only.
//   3 DMA writes 0x12345678 @0x20, then core loads 0x20
//     -> core_rd=0x12345678 one cycle after core_gnt.
//   4 Core store to addr 0x22
//     -> core_gnt=1, mem_WE=0, align_err pulses next cycle; memory @0x20 unchanged.
//   5 rst pulled low during a DMA read grant cycle
//     -> dma_rvalid stays 0; after release the core wins the first tie.
//   6 Idle cycles between requests
//     -> no gnt, mem_WE=0, last_owner unchanged; the next tie goes to the non-last owner.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin share of the single Data_Memory port between the core and a DMA/loader
// Grant is combinational in the request cycle; read data, rvalid and align_err are registered.
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wd,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rd,
  output logic          core_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wd,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rd,
  output logic [AW-1:0] mem_A,
  output logic          mem_WE,
  output logic [DW-1:0] mem_WD,
  input  logic [DW-1:0] mem_RD,
  output logic          align_err
);
  logic last_dma, core_win, dma_win, any_win, win_we, aligned;
  // on a tie the requester that did not own the port last time wins
  always_comb begin
    core_win   = rst & core_req & (~dma_req | last_dma);
    dma_win    = rst & dma_req & (~core_req | ~last_dma);
    any_win    = core_win | dma_win;
    mem_A      = dma_win ? dma_addr : core_addr;
    mem_WD     = dma_win ? dma_wd : core_wd;
    win_we     = dma_win ? dma_we : core_we;
    aligned    = mem_A[1:0] == 2'b00;
    mem_WE     = any_win & win_we & aligned;
    core_gnt   = core_win;
    dma_gnt    = dma_win;
    core_stall = rst & core_req & ~core_win;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last_dma    <= 1'b1;
      core_rvalid <= 1'b0;
      dma_rvalid  <= 1'b0;
      align_err   <= 1'b0;
      core_rd     <= '0;
      dma_rd      <= '0;
    end else begin
      if (any_win) last_dma <= dma_win;
      core_rvalid <= core_win & ~core_we;
      dma_rvalid  <= dma_win & ~dma_we;
      align_err   <= any_win & ~aligned;
      if (core_win & ~core_we) core_rd <= aligned ? mem_RD : '0;
      if (dma_win & ~dma_we) dma_rd <= aligned ? mem_RD : '0;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios then constrained-random traffic against a behavioural model
module tb_dmem_port_arbiter;
  logic clk = 0, rst = 0;
  logic core_req = 0, core_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] core_addr = 0, core_wd = 0, dma_addr = 0, dma_wd = 0;
  logic core_gnt, core_rvalid, core_stall, dma_gnt, dma_rvalid, mem_WE, align_err;
  logic [31:0] core_rd, dma_rd, mem_A, mem_WD, mem_RD;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int passed = 0, total = 0;
  int last_own, win;
  logic [31:0] e_crd, e_drd;
  bit e_crv, e_drv, e_err;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wd(core_wd),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rd(core_rd), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rd(dma_rd),
    .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD), .align_err(align_err)
  );

  always #5 clk = ~clk;
  assign mem_RD = mem[mem_A[7:2]];
  always @(posedge clk) if (mem_WE) mem[mem_A[7:2]] <= mem_WD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_regs();
    chk("core_rvalid", core_rvalid, e_crv);
    chk("dma_rvalid", dma_rvalid, e_drv);
    chk("align_err", align_err, e_err);
    chk("core_rd", core_rd, e_crd);
    chk("dma_rd", dma_rd, e_drd);
  endtask

  task automatic model_reset();
    last_own = 1;
    e_crd = 0; e_drd = 0; e_crv = 0; e_drv = 0; e_err = 0;
  endtask

  task automatic do_reset();
    rst = 0; core_req = 0; dma_req = 0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_mem_WE", mem_WE, 0);
    chk_regs();
    rst = 1;
  endtask

  // one clock cycle: drive, check combinational grant, clock, check registered results
  task automatic cyc(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                     input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
    logic [31:0] a, d;
    bit we, ok;
    core_req = cr; core_we = cw; core_addr = ca; core_wd = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wd = dd;
    #2;
    win = (!cr && !dr) ? -1 : (cr && dr) ? (last_own == 1 ? 0 : 1) : (cr ? 0 : 1);
    a = (win == 1) ? da : ca;
    d = (win == 1) ? dd : cd;
    we = (win == 1) ? dw : cw;
    ok = a[1:0] == 2'b00;
    chk("core_gnt", core_gnt, 32'(win == 0));
    chk("dma_gnt", dma_gnt, 32'(win == 1));
    chk("core_stall", core_stall, 32'(cr && win != 0));
    chk("mem_WE", mem_WE, 32'(win >= 0 && we && ok));
    if (win >= 0) chk("mem_A", mem_A, a);
    if (win >= 0 && we) chk("mem_WD", mem_WD, d);
    @(posedge clk);
    e_crv = 0; e_drv = 0; e_err = (win >= 0) && !ok;
    if (win >= 0) begin
      last_own = win;
      if (!we) begin
        if (win == 0) begin e_crv = 1; e_crd = ok ? ref_mem[a[7:2]] : 0; end
        else begin e_drv = 1; e_drd = ok ? ref_mem[a[7:2]] : 0; end
      end else if (ok) ref_mem[a[7:2]] = d;
    end
    #1;
    chk_regs();
  endtask

  bit pc, pcw, pd, pdw;
  logic [31:0] pca, pcd, pda, pdd;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    do_reset();
    // single core load with no contention
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // contention from reset: core, dma, core, dma
    do_reset();
    repeat (4) cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    // dma write then core read-back
    cyc(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
    cyc(1, 0, 32'h20, 0, 0, 0, 0, 0);
    chk("readback", core_rd, 32'h12345678);
    // misaligned core store is dropped
    cyc(1, 1, 32'h22, 32'hCAFEF00D, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mem20_kept", mem[8], 32'h12345678);
    // misaligned loads still complete with zero data
    cyc(1, 0, 32'h13, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'h31, 0);
    // reset during a dma read grant, after the core owned the port last
    cyc(1, 0, 32'h8, 0, 0, 0, 0, 0);
    dma_req = 1; dma_we = 0; dma_addr = 32'h10; core_req = 0;
    #2;
    chk("pre_rst_dma_gnt", dma_gnt, 1);
    rst = 0;
    #1;
    chk("rst_dma_gnt_low", dma_gnt, 0);
    chk("rst_mem_WE_low", mem_WE, 0);
    model_reset();
    @(posedge clk); #1;
    chk_regs();
    dma_req = 0; rst = 1;
    cyc(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
    // idle gaps keep the owner history
    repeat (3) cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
    cyc(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
    cyc(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
    // random traffic; requesters hold their request until granted, occasionally withdrawing
    pc = 0; pd = 0;
    repeat (600) begin
      if (!pc && $urandom % 3 != 0) begin
        pc = 1; pcw = 1'($urandom % 2); pcd = $urandom;
        pca = ($urandom % 12 == 0) ? ($urandom & 32'hFF) : ($urandom & 32'hFC);
      end else if (pc && $urandom % 12 == 0) pc = 0;
      if (!pd && $urandom % 3 != 0) begin
        pd = 1; pdw = 1'($urandom % 2); pdd = $urandom;
        pda = ($urandom % 12 == 0) ? ($urandom & 32'hFF) : ($urandom & 32'hFC);
      end else if (pd && $urandom % 12 == 0) pd = 0;
      cyc(pc, pcw, pca, pcd, pd, pdw, pda, pdd);
      if (win == 0) pc = 0;
      if (win == 1) pd = 0;
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
